// File: rtl/sw_pkg.sv
// Shared types for the Smith-Waterman score sequencer: base encodings,
// controller state and the {id, score} result record.
package sw_pkg;

    localparam logic [1:0] BASE_A = 2'b10;
    localparam logic [1:0] BASE_G = 2'b11;
    localparam logic [1:0] BASE_T = 2'b00;
    localparam logic [1:0] BASE_C = 2'b01;

    localparam int SW_ID_WIDTH    = 8;
    localparam int SW_SCORE_WIDTH = 12;

    typedef enum logic [2:0] {IDLE, LOAD_Q, READY, STREAM, GAP} seq_state_t;

    typedef struct packed {
        logic [SW_ID_WIDTH-1:0]    id;
        logic [SW_SCORE_WIDTH-1:0] score;
    } result_t;

endpackage

// File: rtl/sw_sync_fifo.sv
// Synchronous show-ahead FIFO: dout always presents the head entry.
module sw_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [AW-1:0] LAST  = AW'(DEPTH - 1);
    localparam logic [CW-1:0] FULLC = CW'(DEPTH);

    logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign full    = (cnt_q == FULLC);
    assign empty   = (cnt_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem_q[rd_q];

    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (do_push) begin
            mem_d[wr_q] = din;
            wr_d        = (wr_q == LAST) ? '0 : wr_q + AW'(1);
        end
        if (do_pop)
            rd_d = (rd_q == LAST) ? '0 : rd_q + AW'(1);
        if (do_push && !do_pop)
            cnt_d = cnt_q + CW'(1);
        else if (do_pop && !do_push)
            cnt_d = cnt_q - CW'(1);
    end

    // Storage is reset too so the head reads as zero out of reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_q <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/sw_score_sequencer.sv
// Query loader, sequence streamer and score/ID pairing in front of ScoringModule.
// Optional perf counters enabled by defining SW_SEQ_PERF_EN.
module sw_score_sequencer
    import sw_pkg::*;
#(
    parameter int SCORE_WIDTH  = SW_SCORE_WIDTH,
    parameter int LENGTH       = 48,
    parameter int LOG_LENGTH   = $clog2(LENGTH),
    parameter int ID_WIDTH     = SW_ID_WIDTH,
    parameter int MAX_INFLIGHT = 4,
    parameter int GAP_CYCLES   = 1,
    parameter logic [SCORE_WIDTH-1:0] ZERO = SCORE_WIDTH'(1 << (SCORE_WIDTH - 1))
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    q_valid,
    output logic                    q_ready,
    input  logic [1:0]              q_base,
    input  logic                    q_last,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [1:0]              s_base,
    input  logic [ID_WIDTH-1:0]     s_id,
    input  logic                    s_last,
    output logic                    sc_en,
    output logic [1:0]              sc_data,
    output logic [2*LENGTH-1:0]     sc_query,
    output logic [LOG_LENGTH-1:0]   sc_sel,
    input  logic                    sc_vld,
    input  logic [SCORE_WIDTH-1:0]  sc_result,
    output logic                    r_valid,
    input  logic                    r_ready,
    output logic [ID_WIDTH-1:0]     r_id,
    output logic [SCORE_WIDTH-1:0]  r_score,
    output logic [LOG_LENGTH:0]     q_len,
    output logic                    q_err,
    output logic                    err_orphan
`ifdef SW_SEQ_PERF_EN
    ,
    output logic [31:0]             perf_seq,
    output logic [31:0]             perf_stall
`endif
);
    localparam int CW = $clog2(MAX_INFLIGHT + 1);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0]       GAP_LAST   = GW'(GAP_CYCLES - 1);
    localparam logic [CW-1:0]       CREDIT_MAX = CW'(MAX_INFLIGHT);
    localparam logic [LOG_LENGTH:0] LEN_MAX    = (LOG_LENGTH + 1)'(LENGTH);

    seq_state_t            state_q, state_d;
    logic [CW-1:0]         credit_q, credit_d;
    logic [GW-1:0]         gap_q, gap_d;
    logic [2*LENGTH-1:0]   sc_query_q, sc_query_d;
    logic [LOG_LENGTH:0]   q_len_q, q_len_d;
    logic [LOG_LENGTH-1:0] sc_sel_q, sc_sel_d;
    logic                  q_err_q, q_err_d, err_orphan_q, err_orphan_d;
    logic                  sc_en_q, sc_en_d;
    logic [1:0]            sc_data_q, sc_data_d;

    logic q_fire, s_fire, r_fire, q_first, id_push, id_pop, res_push;
    logic id_full, id_empty, res_full, res_empty;
    logic [ID_WIDTH-1:0] id_head;
    result_t res_in, res_head;

    assign q_fire   = q_valid && q_ready;
    assign s_fire   = s_valid && s_ready;
    assign r_fire   = r_valid && r_ready;
    assign q_first  = q_fire && (state_q != LOAD_Q);
    assign id_push  = s_fire && (state_q == READY) && !id_full;
    assign id_pop   = sc_vld && !id_empty;
    assign res_push = id_pop && !res_full;
    assign res_in   = '{id: id_head, score: sc_result + ZERO};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, READY: begin
                if (q_fire) begin
                    if (q_last) state_d = READY;
                    else        state_d = LOAD_Q;
                end else if (s_fire) begin
                    if (s_last) state_d = GAP;
                    else        state_d = STREAM;
                end
            end
            LOAD_Q:  if (q_fire && q_last) state_d = READY;
            STREAM:  if (s_fire && s_last) state_d = GAP;
            GAP:     if (gap_q == GAP_LAST) state_d = READY;
            default: state_d = IDLE;
        endcase
    end

    // A pending query reload in READY wins over starting a new sequence.
    always_comb begin
        q_ready = 1'b0;
        s_ready = 1'b0;
        case (state_q)
            IDLE, LOAD_Q: q_ready = 1'b1;
            READY: begin
                q_ready = (credit_q == '0);
                s_ready = (credit_q < CREDIT_MAX) && !(q_valid && credit_q == '0);
            end
            STREAM:  s_ready = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        sc_query_d   = sc_query_q;
        q_len_d      = q_len_q;
        q_err_d      = q_err_q;
        sc_sel_d     = sc_sel_q;
        err_orphan_d = err_orphan_q | (sc_vld && id_empty);
        sc_en_d      = s_fire;
        sc_data_d    = s_fire ? s_base : sc_data_q;
        gap_d        = (state_q == GAP) ? gap_q + GW'(1) : '0;
        credit_d     = credit_q;
        if (q_first) begin
            sc_query_d = '0;
            q_len_d    = '0;
            q_err_d    = 1'b0;
        end
        // Beats past the array length are dropped; q_len saturates at LENGTH.
        if (q_fire) begin
            if (q_len_d < LEN_MAX) begin
                sc_query_d[2*int'(q_len_d) +: 2] = q_base;
                q_len_d = q_len_d + (LOG_LENGTH + 1)'(1);
            end else begin
                q_err_d = 1'b1;
            end
        end
        if (state_q == READY)
            sc_sel_d = LOG_LENGTH'(q_len_q - (LOG_LENGTH + 1)'(1));
        if (id_push && !r_fire)
            credit_d = credit_q + CW'(1);
        else if (r_fire && !id_push)
            credit_d = credit_q - CW'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            credit_q     <= '0;
            gap_q        <= '0;
            sc_query_q   <= '0;
            q_len_q      <= '0;
            sc_sel_q     <= '0;
            q_err_q      <= 1'b0;
            err_orphan_q <= 1'b0;
            sc_en_q      <= 1'b0;
            sc_data_q    <= '0;
        end else begin
            credit_q     <= credit_d;
            gap_q        <= gap_d;
            sc_query_q   <= sc_query_d;
            q_len_q      <= q_len_d;
            sc_sel_q     <= sc_sel_d;
            q_err_q      <= q_err_d;
            err_orphan_q <= err_orphan_d;
            sc_en_q      <= sc_en_d;
            sc_data_q    <= sc_data_d;
        end
    end

    sw_sync_fifo #(.WIDTH(ID_WIDTH), .DEPTH(MAX_INFLIGHT)) u_id_fifo (
        .clk(clk), .rst(rst), .push(id_push), .din(s_id), .pop(id_pop),
        .dout(id_head), .full(id_full), .empty(id_empty)
    );

    sw_sync_fifo #(.WIDTH($bits(result_t)), .DEPTH(MAX_INFLIGHT)) u_res_fifo (
        .clk(clk), .rst(rst), .push(res_push), .din(res_in), .pop(r_fire),
        .dout(res_head), .full(res_full), .empty(res_empty)
    );

    assign sc_en      = sc_en_q;
    assign sc_data    = sc_data_q;
    assign sc_query   = sc_query_q;
    assign sc_sel     = sc_sel_q;
    assign q_len      = q_len_q;
    assign q_err      = q_err_q;
    assign err_orphan = err_orphan_q;
    assign r_valid    = !res_empty;
    assign r_id       = res_head.id;
    assign r_score    = res_head.score;

`ifdef SW_SEQ_PERF_EN
    logic [31:0] perf_seq_q, perf_seq_d, perf_stall_q, perf_stall_d;

    always_comb begin
        perf_seq_d   = perf_seq_q + {31'd0, r_fire};
        perf_stall_d = perf_stall_q + {31'd0, (state_q == READY) && s_valid && !s_ready};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_seq_q   <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_seq_q   <= perf_seq_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_seq   = perf_seq_q;
    assign perf_stall = perf_stall_q;
`endif

endmodule
